// File: rtl/mdr_mem_if_pkg.sv
// mdr_mem_if_pkg: shared types and default constants for the MDR memory interface.
//   mdr_state_e        - access FSM states (IDLE, RD_WAIT, WR_WAIT)
//   DATA_W_DEF         - default MDR / memory data width
//   TIMEOUT_CYCLES_DEF - default mem_req cycle limit per access (timeout build)
package mdr_mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mdr_state_e;

    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/mdr_wait_timer.sv
// mdr_wait_timer: counts wait cycles of one memory access.
//   clk, clr   - clock, synchronous active-high reset (count -> 0)
//   clear_i    - restart the count (held while the FSM is idle, so every
//                access starts from 0)
//   tick_i     - one more wait cycle without mem_ready
//   expired_o  - current cycle is the last one allowed for the access
module mdr_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)     cnt_d = '0;
        else if (tick_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // The count is 0 in the first mem_req cycle, so TIMEOUT_CYCLES-1 marks
    // the final one.
    assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mdr_mem_if.sv
// mdr_mem_if: memory data register plus read/write handshake to memory.
//   clk, clr     - clock, synchronous active-high reset
//   bus_mux_out  - bus value loaded into the MDR on mdr_in (idle only)
//   mdr_in       - MDR load strobe
//   read, write  - start a read into / write from the MDR (read wins)
//   mem_ready    - memory completion strobe; mem_rdata valid with it
//   mdr_q        - MDR contents; mem_wdata mirrors it
//   mem_req/mem_we - access in progress / access is a write
//   busy, done   - not idle / one-cycle completion pulse
//   timeout_err  - sticky timeout flag
// Optional feature: define MDR_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES mem_req cycles without mem_ready. Without it the wait
// states wait indefinitely and timeout_err is 0.
module mdr_mem_if
    import mdr_mem_if_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_mux_out,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mdr_q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);
    mdr_state_e state_q;
    logic       req_q, we_q, done_q, terr_q;
    logic       timeout_hit;

`ifdef MDR_TIMEOUT_EN
    logic expired;

    mdr_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .clr       (clr),
        .clear_i   (state_q == IDLE),
        .tick_i    ((state_q != IDLE) && !mem_ready),
        .expired_o (expired)
    );

    // mem_ready is checked first in the FSM, so a completion in the final
    // cycle wins over the timeout.
    assign timeout_hit = expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Load happens alongside a start: a write sends the new
                    // value, a read later overwrites it.
                    if (mdr_in) mdr_q <= bus_mux_out;
                    if (read) begin
                        state_q <= RD_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                    end else if (write) begin
                        state_q <= WR_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem_ready) begin
                        if (state_q == RD_WAIT) mdr_q <= mem_rdata;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        terr_q  <= 1'b1;
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_wdata   = mdr_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// tb_mdr_mem_if: directed plus randomized checks of mdr_mem_if. The model
// is transaction level: it only tracks what the MDR must hold after each
// load/read/write and the cycle at which done and mem_req must appear.
module tb_mdr_mem_if;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          clr, mdr_in, read, write, mem_ready;
    logic [DW-1:0] bus_mux_out, mem_rdata;
    logic [DW-1:0] mdr_q, mem_wdata;
    logic          mem_req, mem_we, busy, done, timeout_err;

    int total = 0;
    int bad   = 0;

    mdr_mem_if #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .clr         (clr),
        .bus_mux_out (bus_mux_out),
        .mdr_in      (mdr_in),
        .read        (read),
        .write       (write),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mdr_q       (mdr_q),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mdr_in = 0; read = 0; write = 0; mem_ready = 0;
    endtask

    logic [DW-1:0] exp_mdr, d;
    int            req_cnt, done_cnt, lat;

    initial begin
        clr = 1; idle_inputs(); bus_mux_out = '0; mem_rdata = '0;
        tick(); tick();
        clr = 0;
        chk("rst_mdr", mdr_q, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_terr", timeout_err, 0);

        // load 0xA5 then write it, memory answers after 3 wait cycles
        mdr_in = 1; bus_mux_out = 32'h0000_00A5; tick(); mdr_in = 0;
        chk("load_a5", mdr_q, 32'hA5);
        write = 1; tick(); write = 0;
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 32'hA5);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            done_cnt += int'(done);
            tick();
        end
        mem_ready = 1; tick(); mem_ready = 0;
        done_cnt += int'(done);
        chk("wr_busy_after", busy, 0);
        tick();
        done_cnt += int'(done);
        chk("wr_one_done", done_cnt, 1);
        chk("wr_mdr_kept", mdr_q, 32'hA5);

        // zero-wait read: done and data two cycles after read
        read = 1; tick(); read = 0;
        chk("rd_req", mem_req, 1);
        chk("rd_we", mem_we, 0);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_ready = 0;
        chk("rd_done", done, 1);
        chk("rd_data", mdr_q, 32'hDEAD_BEEF);
        // a new request is accepted in the done cycle
        read = 1; tick(); read = 0;
        chk("b2b_req", mem_req, 1);
        chk("b2b_done_low", done, 0);
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D; tick(); mem_ready = 0;
        chk("b2b_data", mdr_q, 32'h0BAD_F00D);

        // read and write together: read wins, write dropped
        read = 1; write = 1; tick(); read = 0; write = 0;
        chk("rw_we", mem_we, 0);
        mem_ready = 1; mem_rdata = 32'h5555_AAAA; tick(); mem_ready = 0;
        chk("rw_done", done, 1);
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            req_cnt += int'(mem_req);
            tick();
        end
        chk("rw_single_access", req_cnt, 0);
        chk("rw_data", mdr_q, 32'h5555_AAAA);

        // mdr_in during RD_WAIT is ignored
        read = 1; tick(); read = 0;
        mdr_in = 1; bus_mux_out = 32'h1234; tick(); mdr_in = 0;
        chk("busy_load_ignored", mdr_q, 32'h5555_AAAA);
        mem_ready = 1; mem_rdata = 32'hCAFE_0001; tick(); mem_ready = 0;
        chk("busy_load_final", mdr_q, 32'hCAFE_0001);

        // mem_ready in IDLE is ignored
        mem_ready = 1; mem_rdata = 32'h7777_7777; tick(); mem_ready = 0;
        chk("idle_ready_mdr", mdr_q, 32'hCAFE_0001);
        chk("idle_ready_done", done, 0);

        // clr during WR_WAIT
        write = 1; tick(); write = 0; tick();
        clr = 1; mem_ready = 1; tick(); clr = 0; mem_ready = 0;
        chk("clr_mdr", mdr_q, 0);
        chk("clr_req", mem_req, 0);
        chk("clr_we", mem_we, 0);
        chk("clr_wdata", mem_wdata, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        tick();
        chk("clr_no_done", done, 0);

        // read that memory never answers
        mdr_in = 1; bus_mux_out = 32'h0000_3C3C; tick(); mdr_in = 0;
        read = 1; tick(); read = 0;
        req_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            req_cnt += int'(mem_req);
            done_cnt += int'(done);
            tick();
        end
`ifdef MDR_TIMEOUT_EN
        chk("to_req_cycles", req_cnt, TO);
        chk("to_err", timeout_err, 1);
        chk("to_no_done", done_cnt, 0);
        chk("to_mdr_kept", mdr_q, 32'h3C3C);
        // sticky through a normal access
        read = 1; tick(); read = 0;
        mem_ready = 1; mem_rdata = 32'h1111_2222; tick(); mem_ready = 0;
        chk("to_sticky", timeout_err, 1);
        clr = 1; tick(); clr = 0;
        chk("to_clr", timeout_err, 0);
        // ready in the final allowed cycle completes normally
        read = 1; tick(); read = 0;
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_last_req", mem_req, 1);
        mem_ready = 1; mem_rdata = 32'h4444_5555; tick(); mem_ready = 0;
        chk("to_last_done", done, 1);
        chk("to_last_data", mdr_q, 32'h4444_5555);
        chk("to_last_noerr", timeout_err, 0);
`else
        chk("nto_req_cycles", req_cnt, 12);
        chk("nto_busy", busy, 1);
        chk("nto_err", timeout_err, 0);
        chk("nto_no_done", done_cnt, 0);
        mem_ready = 1; mem_rdata = 32'h4444_5555; tick(); mem_ready = 0;
        chk("nto_done", done, 1);
        chk("nto_data", mdr_q, 32'h4444_5555);
`endif

        // randomized loads/reads/writes with noise on inputs while busy
        exp_mdr = mdr_q;
        chk("rand_start", mdr_q, exp_mdr);
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(2))
                0: begin
                    d = $urandom;
                    mdr_in = 1; bus_mux_out = d; tick(); mdr_in = 0;
                    exp_mdr = d;
                    chk("rand_load", mdr_q, exp_mdr);
                end
                default: begin
                    logic is_rd;
                    is_rd = ($urandom_range(1) == 1);
                    read = is_rd; write = !is_rd; tick();
                    lat = $urandom_range(2);
                    chk("rand_we", mem_we, !is_rd);
                    for (int i = 0; i < lat; i++) begin
                        mdr_in = $urandom_range(1); read = $urandom_range(1);
                        write = $urandom_range(1); bus_mux_out = $urandom;
                        mem_rdata = $urandom;
                        chk("rand_wait_req", mem_req, 1);
                        chk("rand_wait_wdata", mem_wdata, exp_mdr);
                        tick();
                    end
                    d = $urandom;
                    mem_ready = 1; mem_rdata = d; tick(); idle_inputs();
                    if (is_rd) exp_mdr = d;
                    chk("rand_done", done, 1);
                    chk("rand_mdr", mdr_q, exp_mdr);
                    chk("rand_idle", busy, 0);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
